rom_bus_ctrl: RTL

- 68000-side read controller for the banked 8K x 16 program ROM stages, sitting directly upstream of them.
- Decodes the bank from the CPU word address and drives the registered address and active-low chip enable into the ROMs.
- Absorbs the ROMs' one-clock registered output latency, latches the selected word and returns it with DTACK_n.

---
 rtl/rom_bus_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rom_bus_ctrl.sv
// 68000 read controller for banked 8K x 16 program ROMs: decodes the bank, strobes one
// ROM chip enable for a single clock, absorbs the ROM output register and returns DTACK_n.
module rom_bus_ctrl #(
  parameter int BANK_BITS   = 2,
  parameter int WAIT_STATES = 0,
  localparam int NUM_BANKS  = 2**BANK_BITS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [12+BANK_BITS:0]     cpu_a,
  input  logic                      cpu_as_n,
  input  logic                      cpu_rw,
  input  logic                      rom_sel,
  output logic [15:0]               cpu_d,
  output logic                      cpu_dtack_n,
  output logic                      wr_err,
  output logic [12:0]               rom_a,
  output logic [NUM_BANKS-1:0]      rom_ce_n,
  input  logic [16*NUM_BANKS-1:0]   rom_d
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WAIT, S_LATCH, S_ACK
  } state_t;

  state_t                 state, state_nxt;
  logic [BANK_BITS-1:0]   bank, bank_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [12:0]            rom_a_nxt;
  logic [NUM_BANKS-1:0]   ce_nxt;
  logic [15:0]            d_nxt;
  logic                   dtack_nxt;
  logic                   wr_err_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      bank        <= '0;
      cnt         <= '0;
      rom_a       <= '0;
      rom_ce_n    <= '1;
      cpu_d       <= '0;
      cpu_dtack_n <= 1'b1;
      wr_err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      bank        <= bank_nxt;
      cnt         <= cnt_nxt;
      rom_a       <= rom_a_nxt;
      rom_ce_n    <= ce_nxt;
      cpu_d       <= d_nxt;
      cpu_dtack_n <= dtack_nxt;
      wr_err      <= wr_err_nxt;
    end
  end

  // Chip enables default high so each enable is low for exactly the one SELECT clock.
  always_comb begin
    state_nxt  = state;
    bank_nxt   = bank;
    cnt_nxt    = cnt;
    rom_a_nxt  = rom_a;
    ce_nxt     = '1;
    d_nxt      = cpu_d;
    dtack_nxt  = cpu_dtack_n;
    wr_err_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        dtack_nxt = 1'b1;
        if (!cpu_as_n && rom_sel) begin
          if (cpu_rw) begin
            rom_a_nxt                 = cpu_a[12:0];
            bank_nxt                  = cpu_a[12+BANK_BITS:13];
            ce_nxt[cpu_a[12+BANK_BITS:13]] = 1'b0;
            state_nxt                 = S_SELECT;
          end else begin
            dtack_nxt  = 1'b0;
            wr_err_nxt = 1'b1;
            state_nxt  = S_ACK;
          end
        end
      end
      S_SELECT: begin
        if (cpu_as_n) begin
          dtack_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt   = 4'(WAIT_STATES);
          state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_LATCH;
        end
      end
      S_WAIT: begin
        if (cpu_as_n) begin
          dtack_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt <= 4'd1) state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        if (cpu_as_n) begin
          dtack_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          d_nxt     = rom_d[16*bank +: 16];
          dtack_nxt = 1'b0;
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (cpu_as_n) begin
          dtack_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        dtack_nxt = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
